// File: rtl/burst_demux1to8_if.sv
// Beat stream in, one-hot routed beat stream out, plus completion report.
// master drives beats and per-port ready; slave is the demultiplexer.
interface burst_demux1to8_if #(
    parameter int LEN_W = 5
);
    logic             InValid;
    logic             InReady;
    logic [7:0]       InData;
    logic [2:0]       InSel;
    logic             InLast;
    logic [7:0]       OutData;
    logic [7:0]       OutValid;
    logic             OutLast;
    logic [7:0]       OutReady;
    logic             DoneStrobe;
    logic [2:0]       DoneSel;
    logic [LEN_W-1:0] DoneLen;
    logic             ErrOvf;

    modport master (
        output InValid, InData, InSel, InLast, OutReady,
        input  InReady, OutData, OutValid, OutLast,
        input  DoneStrobe, DoneSel, DoneLen, ErrOvf
    );

    modport slave (
        input  InValid, InData, InSel, InLast, OutReady,
        output InReady, OutData, OutValid, OutLast,
        output DoneStrobe, DoneSel, DoneLen, ErrOvf
    );
endinterface

// File: rtl/burst_demux1to8.sv
// Registered 1:8 burst demultiplexer: locks the destination for a burst,
// caps burst length at MAX_BURST and reports each completed burst.
module burst_demux1to8 #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 5
) (
    input logic Clk,
    input logic Rst_n,
    burst_demux1to8_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [2:0]       cursel_q;
    logic             full_q;
    logic [7:0]       data_q;
    logic             last_q;
    logic [2:0]       regsel_q;
    logic             done_q;
    logic [2:0]       donesel_q;
    logic [LEN_W-1:0] donelen_q;
    logic             ovf_q;

    logic             accept;
    logic             drain;
    logic [2:0]       dest_d;
    logic [LEN_W-1:0] cnt_d;
    logic             cap_d;
    logic             fin_d;
    logic             ovf_d;

    assign bus.InReady = ~full_q | bus.OutReady[regsel_q];
    assign accept      = bus.InValid & bus.InReady;
    assign drain       = full_q & bus.OutReady[regsel_q];

    // Destination and beat number of the beat offered this cycle
    always_comb begin
        dest_d = cursel_q;
        cnt_d  = cnt_q + 1'b1;
        if (state_q == IDLE) begin
            dest_d = bus.InSel;
            cnt_d  = LEN_W'(1);
        end
        cap_d = (cnt_d == LEN_W'(MAX_BURST));
        fin_d = bus.InLast | cap_d;
        ovf_d = ~bus.InLast & cap_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cursel_q  <= '0;
            full_q    <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            regsel_q  <= '0;
            done_q    <= 1'b0;
            donesel_q <= '0;
            donelen_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (accept) begin
                full_q   <= 1'b1;
                data_q   <= bus.InData;
                last_q   <= fin_d;
                regsel_q <= dest_d;
                cursel_q <= dest_d;
                cnt_q    <= cnt_d;
                state_q  <= fin_d ? IDLE : BURST;
                if (fin_d) begin
                    done_q    <= 1'b1;
                    donesel_q <= dest_d;
                    donelen_q <= cnt_d;
                    ovf_q     <= ovf_d;
                end
            end else if (drain) begin
                full_q <= 1'b0;
            end
        end
    end

    assign bus.OutData    = data_q;
    assign bus.OutLast    = last_q;
    assign bus.OutValid   = full_q ? (8'b1 << regsel_q) : 8'b0;
    assign bus.DoneStrobe = done_q;
    assign bus.DoneSel    = donesel_q;
    assign bus.DoneLen    = donelen_q;
    assign bus.ErrOvf     = ovf_q;
endmodule

// File: tb/tb_burst_demux1to8.sv
// Scoreboard bench for burst_demux1to8: a burst-level model queues expected
// beats and completions, a monitor pops them as the DUT presents them.
module tb_burst_demux1to8;
    localparam int MAXB = 16;
    localparam int LW   = 5;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    burst_demux1to8_if #(.LEN_W(LW)) bus();

    burst_demux1to8 #(.MAX_BURST(MAXB), .LEN_W(LW)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] port;
    } beat_t;

    typedef struct packed {
        logic [2:0] sel;
        int         len;
        logic       ovf;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int stalls = 0;
    int ovf_seen = 0;
    int ovf_exp = 0;
    int done_seen = 0;
    bit rand_rdy = 0;

    // Burst-level reference state
    bit       m_inburst = 0;
    int       m_port = 0;
    int       m_n = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_accept(input logic [7:0] d,
                                         input logic [2:0] s,
                                         input logic l);
        beat_t b;
        done_t e;
        bit fin;
        if (!m_inburst) begin
            m_port = int'(s);
            m_n = 0;
        end
        m_n++;
        fin = l || (m_n == MAXB);
        b.data = d;
        b.last = fin;
        b.port = 3'(m_port);
        beat_q.push_back(b);
        if (fin) begin
            e.sel = 3'(m_port);
            e.len = m_n;
            e.ovf = !l;
            if (!l) ovf_exp++;
            done_q.push_back(e);
            m_inburst = 0;
        end else begin
            m_inburst = 1;
        end
    endfunction

    task automatic send(input logic [7:0] d, input logic [2:0] s,
                        input logic l);
        int w;
        w = 0;
        bus.InValid = 1'b1;
        bus.InData = d;
        bus.InSel = s;
        bus.InLast = l;
        @(negedge Clk);
        while (!bus.InReady && w < 200) begin
            w++;
            stalls++;
            @(negedge Clk);
        end
        chk("send_accept", 32'(bus.InReady), 32'd1);
        if (bus.InReady) model_accept(d, s, l);
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        beat_t b;
        done_t e;
        forever begin
            @(negedge Clk);
            if (Rst_n) begin
                if ((bus.OutValid & (bus.OutValid - 8'd1)) != 8'd0)
                    chk("onehot", 32'(bus.OutValid), 32'd0);
                if ((bus.OutValid & bus.OutReady) != 8'd0) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_unexpected", 32'(bus.OutData), 32'hFFFF);
                    end else begin
                        b = beat_q.pop_front();
                        chk("out_valid", 32'(bus.OutValid),
                            32'(8'b1 << b.port));
                        chk("out_data", 32'(bus.OutData), 32'(b.data));
                        chk("out_last", 32'(bus.OutLast), 32'(b.last));
                    end
                end
                if (bus.ErrOvf) ovf_seen++;
                if (bus.ErrOvf && !bus.DoneStrobe)
                    chk("ovf_wo_done", 32'(bus.DoneStrobe), 32'd1);
                if (bus.DoneStrobe) begin
                    done_seen++;
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_sel", 32'(bus.DoneSel), 32'(e.sel));
                        chk("done_len", 32'(bus.DoneLen), 32'(e.len));
                        chk("done_ovf", 32'(bus.ErrOvf), 32'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rand_rdy) bus.OutReady = 8'($urandom);
        end
    end

    initial begin
        int w;
        int s0;
        int d0;
        bus.InValid = 1'b0;
        bus.InData = '0;
        bus.InSel = '0;
        bus.InLast = 1'b0;
        bus.OutReady = 8'hFF;

        // Reset values
        #12;
        chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
        chk("rst_outdata", 32'(bus.OutData), 32'd0);
        chk("rst_outlast", 32'(bus.OutLast), 32'd0);
        chk("rst_done", 32'(bus.DoneStrobe), 32'd0);
        chk("rst_donesel", 32'(bus.DoneSel), 32'd0);
        chk("rst_donelen", 32'(bus.DoneLen), 32'd0);
        chk("rst_ovf", 32'(bus.ErrOvf), 32'd0);
        chk("rst_inready", 32'(bus.InReady), 32'd1);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Routing sweep, one single-beat burst per cycle
        s0 = stalls;
        d0 = done_seen;
        for (int i = 0; i < 8; i++)
            send(8'(8'hFF - 8'h11 * i), 3'(i), 1'b1);
        chk("sweep_stalls", 32'(stalls - s0), 32'd0);
        @(negedge Clk);
        chk("sweep_dones", 32'(done_seen - d0), 32'd8);
        @(posedge Clk);
        #1;

        // Burst lock: InSel changes mid-burst are ignored
        send(8'h11, 3'd5, 1'b0);
        send(8'h22, 3'd2, 1'b0);
        send(8'h33, 3'd2, 1'b0);
        send(8'h44, 3'd2, 1'b1);
        repeat (2) @(posedge Clk);
        #1;

        // Backpressure on port 3
        bus.OutReady = 8'hF7;
        send(8'hA1, 3'd3, 1'b0);
        bus.InValid = 1'b1;
        bus.InData = 8'hA2;
        bus.InSel = 3'd6;
        bus.InLast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("bp_inready", 32'(bus.InReady), 32'd0);
            chk("bp_hold_data", 32'(bus.OutData), 32'hA1);
            chk("bp_hold_valid", 32'(bus.OutValid), 32'h08);
        end
        @(posedge Clk);
        #1;
        bus.OutReady = 8'hFF;
        s0 = stalls;
        send(8'hA2, 3'd6, 1'b0);
        send(8'hA3, 3'd6, 1'b0);
        send(8'hA4, 3'd6, 1'b1);
        chk("bp_resume_stalls", 32'(stalls - s0), 32'd0);
        repeat (2) @(posedge Clk);
        #1;

        // Overflow: 18 beats without InLast
        ovf_seen = 0;
        ovf_exp = 0;
        for (int i = 1; i <= 18; i++)
            send(8'(i), (i >= 17) ? 3'd6 : 3'd1, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        chk("ovf_pulses", 32'(ovf_seen), 32'(ovf_exp));
        chk("ovf_expected", 32'(ovf_exp), 32'(1));
        send(8'h13, 3'd0, 1'b1);

        // Randomized traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 3'($urandom),
                 ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
        for (int i = 0; i < 40; i++)
            send(8'($urandom), 3'($urandom), 1'b0);
        send(8'h5A, 3'($urandom), 1'b1);
        rand_rdy = 0;
        @(posedge Clk);
        #2;
        bus.OutReady = 8'hFF;
        w = 0;
        while ((beat_q.size() != 0 || done_q.size() != 0) && w < 100) begin
            @(posedge Clk);
            w++;
        end
        chk("drain_beats_left", 32'(beat_q.size()), 32'd0);
        chk("drain_done_left", 32'(done_q.size()), 32'd0);
        #1;

        // Reset mid-burst with a beat still held
        send(8'hC1, 3'd4, 1'b0);
        d0 = done_seen;
        send(8'hC2, 3'd4, 1'b0);
        bus.OutReady = 8'h00;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_outvalid", 32'(bus.OutValid), 32'd0);
        chk("mid_rst_done", 32'(bus.DoneStrobe), 32'd0);
        chk("mid_rst_inready", 32'(bus.InReady), 32'd1);
        beat_q.delete();
        done_q.delete();
        m_inburst = 0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        bus.OutReady = 8'hFF;
        send(8'hD7, 3'd7, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        chk("post_rst_dones", 32'(done_seen - d0), 32'd1);
        chk("post_rst_beats_left", 32'(beat_q.size()), 32'd0);
        chk("post_rst_done_left", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/burst_demux1to8.md
Name: burst_demux1to8

Overview:
- Registered 1-to-8 demultiplexer, the distribution end of the unidirectional bus path whose 8:1 select side is Mux8to1.
- Takes one 8-bit beat stream, for example SDRAM read return data, and routes whole bursts to one of 8 consumer ports.
- Flow control is a valid/ready handshake on every port.
- Holds the destination for the length of a burst, caps burst length, and reports completed bursts.

Parameters:
- MAX_BURST, 16: maximum beats per burst; the MAX_BURST-th beat without InLast is forced to end the burst.
- LEN_W, 5: width of the beat counter and DoneLen; requires 2**LEN_W > MAX_BURST.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  upstream beat valid.
- InReady  output  1  block can accept a beat this cycle.
- InData  input  8  beat data.
- InSel  input  3  destination port 0..7; sampled only on the first beat of a burst.
- InLast  input  1  final beat of the burst.
- OutData  output  8  registered data, shared by all 8 ports.
- OutValid  output  8  one-hot valid; bit n means port n (Mux8to1 In(n+1)) owns OutData.
- OutLast  output  1  registered last flag for the beat on OutData.
- OutReady  input  8  per-port ready.
- DoneStrobe  output  1  one-cycle pulse when a burst completes.
- DoneSel  output  3  port of the completed burst.
- DoneLen  output  LEN_W  beats in the completed burst (1..MAX_BURST).
- ErrOvf  output  1  one-cycle pulse when a burst is truncated at MAX_BURST.

Behaviour:
- Reset (async, Rst_n=0): every output register is 0, namely OutValid, OutData, OutLast, DoneStrobe, DoneSel, DoneLen, ErrOvf. Internally: state IDLE, beat count 0, Full=0, CurSel=0. Any burst in flight is discarded with no Done. InReady=1 after reset because Full=0.
- Output stage: one register {OutData, OutLast, RegSel} plus a Full flag.
  - InReady = ~Full | OutReady[RegSel]. This is combinational from OutReady, which gives full throughput.
  - Accept = InValid & InReady.
  - Drain = Full & OutReady[RegSel].
  - OutValid = Full ? (8'b1 << RegSel) : 0.
  - Accept with Drain in the same cycle: the register reloads and Full stays 1.
  - Drain without Accept: Full goes to 0.
  - Latency: a beat accepted at edge k is on OutData / OutValid from edge k until drained; minimum 1 cycle in to out.
  - OutReady bits for ports other than RegSel are ignored.
- Burst FSM:
  - IDLE:
    - On Accept, the destination is InSel; CurSel<=InSel; count<=1.
    - If InLast=1, or MAX_BURST=1, the burst is a single beat and the state stays IDLE.
    - Otherwise go to BURST.
  - BURST:
    - On Accept, the destination is CurSel; InSel is ignored; count<=count+1.
    - If InLast=1, go to IDLE.
    - If count+1==MAX_BURST and InLast=0: force OutLast=1 on that beat, pulse ErrOvf, go to IDLE. Subsequent beats form a new burst using the InSel present at that time.
  - No Accept: state and count hold. InValid dropping mid-burst does not end the burst.
- Completion: on the edge where the final beat (real or forced last) is accepted:
  - DoneStrobe<=1, DoneSel<=destination, DoneLen<=beat count including that beat.
  - DoneStrobe and ErrOvf are high for exactly one cycle, aligned with that beat first appearing on OutData.
  - DoneSel and DoneLen hold until the next completion.
- Back-to-back: a new burst may start on the cycle after the last beat is accepted. A single-beat burst each cycle gives a DoneStrobe every cycle.
- Counter width: the count never exceeds MAX_BURST and never wraps.

Test Plan:
- Routing sweep: single-beat bursts, InSel 0..7 with data FF,EE,DD,CC,BB,AA,99,88, all OutReady=8'hFF.
  - Required: OutValid = 01,02,04,...,80 with matching data, one per cycle.
  - Required: DoneStrobe every cycle with DoneLen=1.
- Burst lock: 4-beat burst to port 5 (data 11,22,33,44); InSel toggled to 2 mid-burst.
  - Required: all four beats on OutValid=8'h20; OutLast only on 44.
  - Required: DoneSel=5, DoneLen=4.
- Backpressure: burst to port 3 with OutReady[3]=0 for 3 cycles, while OutReady for the other ports is 1.
  - Required: InReady=0 while Full; the beat is held stable.
  - Required: no loss or duplication after OutReady[3]=1; throughput 1 beat/cycle resumes.
- Overflow: 18 beats with no InLast to port 1, MAX_BURST=16.
  - Required: beat 16 has OutLast=1; ErrOvf and DoneStrobe pulse with DoneLen=16.
  - Required: beats 17-18 start a new burst using InSel at beat 17.
- Reset mid-burst: Rst_n low asynchronously after beat 2 of a 4-beat burst.
  - Required: OutValid=0 immediately, with no DoneStrobe.
  - Required: after release, the next beat is treated as a new burst with fresh InSel.
